// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter: FSM state encoding, grant
// owner encoding, RAM access size / direction codes and the alignment helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        EXT_ACC = 2'd2,
        RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_EXT = 1'b1
    } owner_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

    // A word access must sit on a 4-byte boundary; byte accesses never fault.
    function automatic logic is_misaligned(input logic size, input logic [1:0] addr_lo);
        return (size == SIZE_WORD) && (addr_lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_arb_req_latch.sv
// dmem_arb_req_latch
// Holds the attributes of the granted request (rw, size, addr, wdata) so the
// RAM sees stable values for the whole access even if the requester changes
// or drops its inputs.
// Ports:
//   clk, reset         clock / asynchronous active-low reset
//   load               capture enable (asserted on a grant)
//   src_rw .. src_wdata  attributes of the winning port
//   rw .. wdata        captured attributes
module dmem_arb_req_latch
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              src_rw,
    input  logic              src_size,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [31:0]       src_wdata,
    output logic              rw,
    output logic              size,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata
);

    logic              rw_r;
    logic              size_r;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       wdata_r;

    // Capture the winning request on a grant, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rw_r    <= RW_READ;
            size_r  <= SIZE_BYTE;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
        end else if (load) begin
            rw_r    <= src_rw;
            size_r  <= src_size;
            addr_r  <= src_addr;
            wdata_r <= src_wdata;
        end else begin
            rw_r    <= rw_r;
            size_r  <= size_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    assign rw    = rw_r;
    assign size  = size_r;
    assign addr  = addr_r;
    assign wdata = wdata_r;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-port data RAM between the pipeline MEM stage (cpu port)
// and an external loader/debug port (ext port). Models a RAM latency of
// WAIT_CYCLES+1 access cycles, stalls the pipeline while a cpu access waits
// or runs, and gives ext priority once it has lost STARVE_LIMIT cycles.
// Optional build macro: DMEM_ARB_PERF_EN adds saturating grant/stall counters.
// Ports:
//   clk, reset                         clock / asynchronous active-low reset
//   cpu_req/rw/size/addr/wdata         MEM-stage request
//   cpu_rdata, cpu_stall               load data, pipeline freeze
//   ext_req/rw/size/addr/wdata         external request (held until ext_ack)
//   ext_rdata, ext_ack                 read data, completion pulse
//   err                                misaligned word access pulse
//   cpu_grant_cnt, ext_grant_cnt, stall_cnt  (DMEM_ARB_PERF_EN only)
//   ram_enable/rw/size/addr/din, ram_dout   RAM interface
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic              cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_req,
    input  logic              ext_rw,
    input  logic              ext_size,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [31:0]       ext_wdata,
    output logic [31:0]       ext_rdata,
    output logic              ext_ack,
    output logic              err,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]       cpu_grant_cnt,
    output logic [15:0]       ext_grant_cnt,
    output logic [15:0]       stall_cnt,
`endif
    output logic              ram_enable,
    output logic              ram_rw,
    output logic              ram_size,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam logic [3:0] WAIT_C  = 4'(WAIT_CYCLES);
    localparam logic [3:0] STARVE_C = 4'(STARVE_LIMIT);

    arb_state_e        state_r;
    owner_e            owner_r;
    logic [3:0]        wait_cnt_r;
    logic [3:0]        starve_cnt_r;
    logic [31:0]       cpu_rdata_r;
    logic [31:0]       ext_rdata_r;
    logic              ext_ack_r;
    logic              err_r;
    logic              ram_enable_r;

    logic              grant_cpu_s;
    logic              grant_ext_s;
    logic              load_s;
    logic              mis_s;
    logic              ext_busy_s;
    logic              sel_rw_s;
    logic              sel_size_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [31:0]       sel_wdata_s;
    logic              lat_rw_s;
    logic              lat_size_s;
    logic [ADDR_W-1:0] lat_addr_s;
    logic [31:0]       lat_wdata_s;

    // Arbitration: cpu wins unless ext has been starved long enough
    always_comb begin
        grant_cpu_s = 1'b0;
        grant_ext_s = 1'b0;
        if (state_r == IDLE) begin
            if (cpu_req && (!ext_req || (starve_cnt_r < STARVE_C))) begin
                grant_cpu_s = 1'b1;
            end else if (ext_req) begin
                grant_ext_s = 1'b1;
            end else begin
                grant_cpu_s = 1'b0;
            end
        end else begin
            grant_ext_s = 1'b0;
        end
    end

    // Select the winning port's attributes for capture
    always_comb begin
        sel_rw_s    = grant_ext_s ? ext_rw    : cpu_rw;
        sel_size_s  = grant_ext_s ? ext_size  : cpu_size;
        sel_addr_s  = grant_ext_s ? ext_addr  : cpu_addr;
        sel_wdata_s = grant_ext_s ? ext_wdata : cpu_wdata;
        load_s      = grant_cpu_s | grant_ext_s;
        mis_s       = is_misaligned(sel_size_s, sel_addr_s[1:0]);
        // ext holds the grant from its ACC state through its RESP cycle
        ext_busy_s  = (state_r == EXT_ACC) || ((state_r == RESP) && (owner_r == OWNER_EXT));
    end

    dmem_arb_req_latch #(
        .ADDR_W (ADDR_W)
    ) u_req_latch (
        .clk       (clk),
        .reset     (reset),
        .load      (load_s),
        .src_rw    (sel_rw_s),
        .src_size  (sel_size_s),
        .src_addr  (sel_addr_s),
        .src_wdata (sel_wdata_s),
        .rw        (lat_rw_s),
        .size      (lat_size_s),
        .addr      (lat_addr_s),
        .wdata     (lat_wdata_s)
    );

    // Access FSM with registered RAM enable, ack, err and read-data outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            owner_r      <= OWNER_CPU;
            wait_cnt_r   <= 4'd0;
            cpu_rdata_r  <= 32'h0000_0000;
            ext_rdata_r  <= 32'h0000_0000;
            ext_ack_r    <= 1'b0;
            err_r        <= 1'b0;
            ram_enable_r <= 1'b0;
        end else begin
            ext_ack_r <= 1'b0;
            err_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (load_s) begin
                        owner_r    <= grant_ext_s ? OWNER_EXT : OWNER_CPU;
                        wait_cnt_r <= WAIT_C;
                        if (mis_s) begin
                            // Fault skips the RAM entirely and answers with zero data
                            state_r      <= RESP;
                            err_r        <= 1'b1;
                            ram_enable_r <= 1'b0;
                            if (grant_ext_s) begin
                                ext_rdata_r <= 32'h0000_0000;
                                ext_ack_r   <= 1'b1;
                            end else begin
                                cpu_rdata_r <= 32'h0000_0000;
                            end
                        end else begin
                            state_r      <= grant_ext_s ? EXT_ACC : CPU_ACC;
                            ram_enable_r <= 1'b1;
                        end
                    end else begin
                        state_r      <= IDLE;
                        ram_enable_r <= 1'b0;
                    end
                end
                CPU_ACC, EXT_ACC: begin
                    if (wait_cnt_r == 4'd0) begin
                        state_r      <= RESP;
                        ram_enable_r <= 1'b0;
                        ext_ack_r    <= (owner_r == OWNER_EXT);
                        if (lat_rw_s == RW_READ) begin
                            if (owner_r == OWNER_EXT) begin
                                ext_rdata_r <= ram_dout;
                            end else begin
                                cpu_rdata_r <= ram_dout;
                            end
                        end else begin
                            cpu_rdata_r <= cpu_rdata_r;
                        end
                    end else begin
                        wait_cnt_r   <= wait_cnt_r - 4'd1;
                        ram_enable_r <= 1'b1;
                    end
                end
                RESP: begin
                    state_r      <= IDLE;
                    ram_enable_r <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    ram_enable_r <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter: counts cycles ext waits without holding the grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_ext_s) begin
            starve_cnt_r <= 4'd0;
        end else if (ext_req && !ext_busy_s && (starve_cnt_r < STARVE_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    // Stall is released only in the cpu's own RESP cycle; forced low in reset
    assign cpu_stall  = reset & cpu_req & ~((state_r == RESP) & (owner_r == OWNER_CPU));

    assign cpu_rdata  = cpu_rdata_r;
    assign ext_rdata  = ext_rdata_r;
    assign ext_ack    = ext_ack_r;
    assign err        = err_r;
    assign ram_enable = ram_enable_r;
    assign ram_rw     = lat_rw_s;
    assign ram_size   = lat_size_s;
    assign ram_addr   = lat_addr_s;
    assign ram_din    = lat_wdata_s;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] cpu_grant_cnt_r;
    logic [15:0] ext_grant_cnt_r;
    logic [15:0] stall_cnt_r;

    // Saturating grant and stall statistics
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_grant_cnt_r <= 16'h0000;
            ext_grant_cnt_r <= 16'h0000;
            stall_cnt_r     <= 16'h0000;
        end else begin
            if (grant_cpu_s && (cpu_grant_cnt_r != 16'hFFFF)) begin
                cpu_grant_cnt_r <= cpu_grant_cnt_r + 16'h0001;
            end else begin
                cpu_grant_cnt_r <= cpu_grant_cnt_r;
            end
            if (grant_ext_s && (ext_grant_cnt_r != 16'hFFFF)) begin
                ext_grant_cnt_r <= ext_grant_cnt_r + 16'h0001;
            end else begin
                ext_grant_cnt_r <= ext_grant_cnt_r;
            end
            if (cpu_stall && (stall_cnt_r != 16'hFFFF)) begin
                stall_cnt_r <= stall_cnt_r + 16'h0001;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign cpu_grant_cnt = cpu_grant_cnt_r;
    assign ext_grant_cnt = ext_grant_cnt_r;
    assign stall_cnt     = stall_cnt_r;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter (WAIT_CYCLES=1, STARVE_LIMIT=4). A
// transaction-level model tracks each granted access by its age in cycles and
// predicts stall, RAM enable, ack, err and read data every cycle; literal
// expectations per scenario pin the model.
module tb_dmem_arbiter;

    localparam int ADDR_W = 8;
    localparam int WAIT   = 1;
    localparam int LIMIT  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              cpu_req, cpu_rw, cpu_size;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata, cpu_rdata;
    logic              cpu_stall;
    logic              ext_req, ext_rw, ext_size;
    logic [ADDR_W-1:0] ext_addr;
    logic [31:0]       ext_wdata, ext_rdata;
    logic              ext_ack, err;
    logic              ram_enable, ram_rw, ram_size;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din, ram_dout;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0]       cpu_grant_cnt, ext_grant_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .WAIT_CYCLES  (WAIT),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_rw     (cpu_rw),
        .cpu_size   (cpu_size),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ext_req    (ext_req),
        .ext_rw     (ext_rw),
        .ext_size   (ext_size),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .ext_ack    (ext_ack),
        .err        (err),
`ifdef DMEM_ARB_PERF_EN
        .cpu_grant_cnt (cpu_grant_cnt),
        .ext_grant_cnt (ext_grant_cnt),
        .stall_cnt     (stall_cnt),
`endif
        .ram_enable (ram_enable),
        .ram_rw     (ram_rw),
        .ram_size   (ram_size),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    int checks = 0;
    int errors = 0;

    // Model: age of the current transaction (-1 = no transaction, 1 = first
    // cycle after the grant) plus the captured request and read-data copies.
    int          m_age = -1;
    bit          m_ext, m_mis, m_rw, m_size;
    logic [7:0]  m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_cpu_rdata = 32'h0;
    logic [31:0] m_ext_rdata = 32'h0;
    int          m_starve = 0;

    int cnt_stall, cnt_en, cnt_ack, cnt_err, ack_step, sc_step;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic new_scn();
        cnt_stall = 0; cnt_en = 0; cnt_ack = 0; cnt_err = 0;
        ack_step = -1; sc_step = 0;
    endtask

    task automatic idle_inputs();
        cpu_req = 1'b0; cpu_rw = 1'b0; cpu_size = 1'b0; cpu_addr = 8'h00; cpu_wdata = 32'h0;
        ext_req = 1'b0; ext_rw = 1'b0; ext_size = 1'b0; ext_addr = 8'h00; ext_wdata = 32'h0;
    endtask

    // One clock: compare at negedge, advance the model at posedge, then
    // return just after the edge so the caller can drive new inputs.
    task automatic step();
        logic resp_e, en_e, stall_e;
        int g;
        @(negedge clk);
        resp_e  = (m_age >= 1) && (m_mis ? (m_age == 1) : (m_age == WAIT + 2));
        en_e    = (m_age >= 1) && !m_mis && (m_age <= WAIT + 1);
        stall_e = cpu_req && !(resp_e && !m_ext);
        chk1("cpu_stall", cpu_stall, stall_e);
        chk1("ram_enable", ram_enable, en_e);
        chk1("ext_ack", ext_ack, resp_e && m_ext);
        chk1("err", err, resp_e && m_mis);
        chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
        chk("ext_rdata", ext_rdata, m_ext_rdata);
        if (en_e) begin
            chk1("ram_rw", ram_rw, m_rw);
            chk1("ram_size", ram_size, m_size);
            chk("ram_addr", {24'h0, ram_addr}, {24'h0, m_addr});
            chk("ram_din", ram_din, m_wdata);
        end
        if (cpu_stall)  cnt_stall++;
        if (ram_enable) cnt_en++;
        if (err)        cnt_err++;
        if (ext_ack) begin
            cnt_ack++;
            if (ack_step < 0) ack_step = sc_step;
        end
        sc_step++;
        @(posedge clk);
        if (m_age < 0) begin
            g = 0;
            if (cpu_req && (!ext_req || m_starve < LIMIT)) g = 1;
            else if (ext_req) g = 2;
            if (g == 2) m_starve = 0;
            else if (ext_req && m_starve < LIMIT) m_starve++;
            if (g != 0) begin
                m_ext   = (g == 2);
                m_rw    = m_ext ? ext_rw    : cpu_rw;
                m_size  = m_ext ? ext_size  : cpu_size;
                m_addr  = m_ext ? ext_addr  : cpu_addr;
                m_wdata = m_ext ? ext_wdata : cpu_wdata;
                m_mis   = m_size && (m_addr[1:0] != 2'b00);
                if (m_mis) begin
                    if (m_ext) m_ext_rdata = 32'h0;
                    else       m_cpu_rdata = 32'h0;
                end
                m_age = 1;
            end
        end else begin
            if (ext_req && !m_ext && m_starve < LIMIT) m_starve++;
            if (!m_mis && !m_rw && m_age == WAIT + 1) begin
                if (m_ext) m_ext_rdata = ram_dout;
                else       m_cpu_rdata = ram_dout;
            end
            m_age = resp_e ? -1 : m_age + 1;
        end
        #1;
    endtask

    initial begin
        idle_inputs();
        ram_dout = 32'h0;
        reset = 1'b0;
        #2;
        chk1("rst_stall", cpu_stall, 1'b0);
        chk1("rst_ram_enable", ram_enable, 1'b0);
        chk1("rst_ext_ack", ext_ack, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ext_rdata", ext_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();

        // 1: cpu word read at 0x10
        new_scn();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_size = 1'b1; cpu_addr = 8'h10;
        ram_dout = 32'hDEADBEEF;
        repeat (4) step();
        idle_inputs();
        step();
        chk("t1_stall_cycles", cnt_stall, 32'd3);
        chk("t1_enable_cycles", cnt_en, 32'd2);
        chk("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // 2: ext byte write of A5 at 0x03
        new_scn();
        ext_req = 1'b1; ext_rw = 1'b1; ext_size = 1'b0; ext_addr = 8'h03; ext_wdata = 32'h000000A5;
        repeat (4) step();
        idle_inputs();
        step();
        chk("t2_enable_cycles", cnt_en, 32'd2);
        chk("t2_ack_count", cnt_ack, 32'd1);
        chk("t2_ack_step", ack_step, 32'd3);
        chk("t2_cpu_rdata_kept", cpu_rdata, 32'hDEADBEEF);

        // 3: simultaneous requests, cpu first then ext
        new_scn();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_size = 1'b1; cpu_addr = 8'h20;
        ext_req = 1'b1; ext_rw = 1'b0; ext_size = 1'b1; ext_addr = 8'h24;
        ram_dout = 32'h11111111;
        repeat (4) step();
        cpu_req = 1'b0;
        ram_dout = 32'h22222222;
        repeat (4) step();
        idle_inputs();
        step();
        chk("t3_cpu_rdata", cpu_rdata, 32'h11111111);
        chk("t3_ext_rdata", ext_rdata, 32'h22222222);
        chk("t3_ack_step", ack_step, 32'd7);
        chk("t3_stall_cycles", cnt_stall, 32'd3);

        // 4: cpu hammers, ext wins after four lost cycles
        new_scn();
        cpu_req = 1'b1; cpu_rw = 1'b1; cpu_size = 1'b1; cpu_addr = 8'h40; cpu_wdata = 32'hCAFEF00D;
        ext_req = 1'b1; ext_rw = 1'b0; ext_size = 1'b1; ext_addr = 8'h44;
        ram_dout = 32'h0BADF00D;
        repeat (8) step();
        ext_req = 1'b0;
        repeat (4) step();
        idle_inputs();
        step();
        chk("t4_ack_step", ack_step, 32'd7);
        chk("t4_stall_cycles", cnt_stall, 32'd10);
        chk("t4_ext_rdata", ext_rdata, 32'h0BADF00D);
        chk("t4_cpu_rdata_kept", cpu_rdata, 32'h11111111);

        // 5: misaligned cpu word read at 0x05
        new_scn();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_size = 1'b1; cpu_addr = 8'h05;
        ram_dout = 32'h55555555;
        repeat (2) step();
        idle_inputs();
        step();
        chk("t5_stall_cycles", cnt_stall, 32'd1);
        chk("t5_enable_cycles", cnt_en, 32'd0);
        chk("t5_err_cycles", cnt_err, 32'd1);
        chk("t5_cpu_rdata", cpu_rdata, 32'h0);

        // 6: reset during CPU_ACC, then a fresh byte read
        new_scn();
        cpu_req = 1'b1; cpu_rw = 1'b0; cpu_size = 1'b1; cpu_addr = 8'h30;
        ram_dout = 32'h77777777;
        step();
        reset = 1'b0;
        #1;
        chk1("t6_stall", cpu_stall, 1'b0);
        chk1("t6_ram_enable", ram_enable, 1'b0);
        chk1("t6_ram_rw", ram_rw, 1'b0);
        chk1("t6_ram_size", ram_size, 1'b0);
        chk("t6_ram_addr", {24'h0, ram_addr}, 32'h0);
        chk("t6_ext_rdata", ext_rdata, 32'h0);
        chk1("t6_ext_ack", ext_ack, 1'b0);
        chk1("t6_err", err, 1'b0);
        m_age = -1; m_starve = 0; m_cpu_rdata = 32'h0; m_ext_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        new_scn();
        cpu_size = 1'b0; cpu_addr = 8'h07;
        ram_dout = 32'h000000EE;
        repeat (4) step();
        idle_inputs();
        step();
        chk("t6_stall_cycles", cnt_stall, 32'd3);
        chk("t6_cpu_rdata", cpu_rdata, 32'h000000EE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
